// File: rtl/match_controller.sv
// Quidditch match sequencer: 1 Hz tick enable, match clock, pause, goal hold, scoring and winner.
// All outputs registered, 1-cycle latency from a sampled pulse; inputs are pulses and are never stalled.
module match_controller #(
  parameter int CLK_HZ     = 50000000,
  parameter int MATCH_SEC  = 180,
  parameter int HOLD_SEC   = 2,
  parameter int GOAL_PTS   = 10,
  parameter int SNITCH_PTS = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       goal_a_p,
  input  logic       goal_b_p,
  input  logic       snitch_a_p,
  input  logic       snitch_b_p,
  output logic [2:0] state,
  output logic       playing,
  output logic       game_over,
  output logic       tick_1hz,
  output logic [7:0] time_left,
  output logic [9:0] score_a,
  output logic [9:0] score_b,
  output logic [1:0] winner
);

  localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [7:0]      MATCH_T  = 8'(MATCH_SEC);
  localparam logic [3:0]      HOLD_T   = 4'(HOLD_SEC);
  localparam logic [10:0]     GOAL_W   = 11'(GOAL_PTS);
  localparam logic [10:0]     SNITCH_W = 11'(SNITCH_PTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAYING = 3'd1,
    S_PAUSED  = 3'd2,
    S_HOLD    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    hold_q, hold_d;
  logic [7:0]    time_d;
  logic [9:0]    score_a_d, score_b_d;
  logic [1:0]    winner_d;
  logic          wrap;

  // Sum is formed one bit wider so the clamp sees true overflow past 999.
  function automatic logic [9:0] sat_add(input logic [9:0] s, input logic [10:0] pts);
    logic [10:0] sum;
    sum = {1'b0, s} + pts;
    return (sum > 11'd999) ? 10'd999 : sum[9:0];
  endfunction

  assign wrap  = ((state_q == S_PLAYING) || (state_q == S_HOLD)) && (pre_q == PRE_MAX);
  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    hold_d    = hold_q;
    time_d    = time_left;
    score_a_d = score_a;
    score_b_d = score_b;
    winner_d  = winner;

    case (state_q)
      S_IDLE, S_OVER: begin
        pre_d = '0;
        if (start_p) begin
          state_d   = S_PLAYING;
          time_d    = MATCH_T;
          score_a_d = '0;
          score_b_d = '0;
          winner_d  = 2'b00;
        end
      end

      S_PLAYING: begin
        if (snitch_a_p || snitch_b_p) begin
          // A wins a simultaneous catch; the tick is dropped on a snitch cycle.
          if (snitch_a_p) score_a_d = sat_add(score_a, SNITCH_W);
          else            score_b_d = sat_add(score_b, SNITCH_W);
          state_d = S_OVER;
          pre_d   = '0;
        end else begin
          pre_d = wrap ? '0 : pre_q + PW'(1);
          if (goal_a_p) score_a_d = sat_add(score_a, GOAL_W);
          if (goal_b_p) score_b_d = sat_add(score_b, GOAL_W);
          if (goal_a_p || goal_b_p) begin
            state_d = S_HOLD;
            hold_d  = HOLD_T;
            pre_d   = '0;
          end else if (pause_p) begin
            state_d = S_PAUSED;
            if (!wrap) pre_d = pre_q;
          end
          if (wrap) begin
            if (time_left != 8'd0) time_d = time_left - 8'd1;
            if (time_left <= 8'd1) state_d = S_OVER;
          end
        end
      end

      S_PAUSED: begin
        if (pause_p) state_d = S_PLAYING;
      end

      S_HOLD: begin
        pre_d = wrap ? '0 : pre_q + PW'(1);
        if (wrap) begin
          if (hold_q <= 4'd1) begin
            hold_d  = 4'd0;
            state_d = S_PLAYING;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
      end
    endcase

    if ((state_d == S_OVER) && (state_q != S_OVER)) begin
      if (score_a_d > score_b_d)      winner_d = 2'b01;
      else if (score_b_d > score_a_d) winner_d = 2'b10;
      else                            winner_d = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      hold_q    <= 4'd0;
      time_left <= MATCH_T;
      score_a   <= 10'd0;
      score_b   <= 10'd0;
      winner    <= 2'b00;
      tick_1hz  <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      hold_q    <= hold_d;
      time_left <= time_d;
      score_a   <= score_a_d;
      score_b   <= score_b_d;
      winner    <= winner_d;
      tick_1hz  <= wrap;
      playing   <= (state_d == S_PLAYING);
      game_over <= (state_d == S_OVER);
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed scenarios plus randomized pulses against a per-cycle game model.
module tb_match_controller;

  localparam int HZ = 10;
  localparam int MS = 5;
  localparam int HS = 2;
  localparam int GP = 10;
  localparam int SP = 150;
  localparam logic [35:0] RST_VEC = {3'd0, 1'b0, 1'b0, 1'b0, 8'd5, 10'd0, 10'd0, 2'd0};

  logic       clk = 1'b0;
  logic       reset;
  logic       start_p, pause_p, goal_a_p, goal_b_p, snitch_a_p, snitch_b_p;
  logic [2:0] state;
  logic       playing, game_over, tick_1hz;
  logic [7:0] time_left;
  logic [9:0] score_a, score_b;
  logic [1:0] winner;
  logic [35:0] obs;

  int checks = 0;
  int errors = 0;

  // Game model: states 0 idle, 1 playing, 2 paused, 3 hold, 4 over.
  int m_st, m_pre, m_hold, m_time, m_sa, m_sb, m_win, m_tick;

  match_controller #(
    .CLK_HZ(HZ), .MATCH_SEC(MS), .HOLD_SEC(HS), .GOAL_PTS(GP), .SNITCH_PTS(SP)
  ) dut (
    .clk(clk), .reset(reset),
    .start_p(start_p), .pause_p(pause_p),
    .goal_a_p(goal_a_p), .goal_b_p(goal_b_p),
    .snitch_a_p(snitch_a_p), .snitch_b_p(snitch_b_p),
    .state(state), .playing(playing), .game_over(game_over), .tick_1hz(tick_1hz),
    .time_left(time_left), .score_a(score_a), .score_b(score_b), .winner(winner)
  );

  always #5 clk = ~clk;

  assign obs = {state, playing, game_over, tick_1hz, time_left, score_a, score_b, winner};

  function automatic int addp(input int s, input int p);
    return (s + p > 999) ? 999 : s + p;
  endfunction

  function automatic logic [35:0] m_vec();
    return {3'(m_st), (m_st == 1), (m_st == 4), 1'(m_tick), 8'(m_time),
            10'(m_sa), 10'(m_sb), 2'(m_win)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_pre = 0; m_hold = 0; m_time = MS;
    m_sa = 0; m_sb = 0; m_win = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit st, input bit ps, input bit ga, input bit gb,
                            input bit sna, input bit snb);
    bit tk;
    int nst;
    tk     = ((m_st == 1) || (m_st == 3)) && (m_pre == HZ - 1);
    m_tick = tk ? 1 : 0;
    nst    = m_st;
    if (m_st == 0 || m_st == 4) begin
      m_pre = 0;
      if (st) begin
        nst = 1; m_time = MS; m_sa = 0; m_sb = 0; m_win = 0;
      end
    end else if (m_st == 1) begin
      if (sna || snb) begin
        if (sna) m_sa = addp(m_sa, SP);
        else     m_sb = addp(m_sb, SP);
        nst = 4; m_pre = 0;
      end else begin
        if (ga) m_sa = addp(m_sa, GP);
        if (gb) m_sb = addp(m_sb, GP);
        if (ga || gb || tk) m_pre = 0;
        else if (!ps)       m_pre = m_pre + 1;
        if (ga || gb) begin
          nst = 3; m_hold = HS;
        end else if (ps) begin
          nst = 2;
        end
        if (tk) begin
          if (m_time > 0) m_time = m_time - 1;
          if (m_time == 0) nst = 4;
        end
      end
    end else if (m_st == 2) begin
      if (ps) nst = 1;
    end else if (m_st == 3) begin
      if (tk) begin
        m_pre = 0; m_hold = m_hold - 1;
        if (m_hold == 0) nst = 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (nst == 4 && m_st != 4)
      m_win = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 3;
    m_st = nst;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(start_p, pause_p, goal_a_p, goal_b_p, snitch_a_p, snitch_b_p);
    #1;
    start_p = 0; pause_p = 0; goal_a_p = 0; goal_b_p = 0; snitch_a_p = 0; snitch_b_p = 0;
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL reset_async: got %h exp %h", obs, RST_VEC);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL reset_held: got %h exp %h", obs, RST_VEC);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_full_match();
    int ticks = 0, last_t = MS, last_c = 0, over_c = -1;
    start_p = 1; step();
    for (int c = 1; c <= 60; c++) begin
      step();
      checks++;
      if (obs !== m_vec()) begin
        errors++; $display("FAIL full_match c%0d: got %h exp %h", c, obs, m_vec());
      end
      if (tick_1hz) ticks++;
      if (int'(time_left) != last_t) begin
        checks++;
        if (c - last_c != 10) begin
          errors++; $display("FAIL step_period: got %0d exp 10", c - last_c);
        end
        last_c = c; last_t = int'(time_left);
      end
      if (game_over && over_c < 0) over_c = c;
    end
    checks++;
    if (ticks != 5) begin errors++; $display("FAIL tick_count: got %0d exp 5", ticks); end
    checks++;
    if (over_c != 50) begin errors++; $display("FAIL over_cycle: got %0d exp 50", over_c); end
    checks++;
    if ({winner, time_left} !== {2'b11, 8'd0}) begin
      errors++; $display("FAIL full_match_end: got w%b t%0d exp w11 t0", winner, time_left);
    end
  endtask

  task automatic test_goal_hold();
    int n = 0;
    hard_reset();
    start_p = 1; step();
    repeat (10 + $urandom_range(0, 8)) step();
    checks++;
    if (time_left !== 8'd4) begin errors++; $display("FAIL goal_pre_time: got %0d exp 4", time_left); end
    goal_a_p = 1; step();
    checks++;
    if ({score_a, state} !== {10'd10, 3'd3}) begin
      errors++; $display("FAIL goal_enter: got a%0d s%0d exp a10 s3", score_a, state);
    end
    for (int i = 1; i < 20; i++) begin
      step();
      checks++;
      if ({state, time_left} !== {3'd3, 8'd4} || obs !== m_vec()) begin
        errors++; $display("FAIL goal_hold i%0d: got %h exp %h", i, obs, m_vec());
      end
    end
    step();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL hold_exit: got %0d exp 1", state); end
    while (time_left == 8'd4 && n < 30) begin step(); n++; end
    checks++;
    if (n != 10) begin errors++; $display("FAIL hold_next_dec: got %0d exp 10", n); end
    for (int i = 0; i < 200 && !game_over; i++) step();
    checks++;
    if ({game_over, winner} !== 3'b101 || obs !== m_vec()) begin
      errors++; $display("FAIL goal_winner: got %h exp %h", obs, m_vec());
    end
  endtask

  task automatic test_double_goal();
    int entries = 0;
    logic [2:0] prev;
    hard_reset();
    start_p = 1; step();
    repeat ($urandom_range(0, 8)) step();
    goal_a_p = 1; goal_b_p = 1; step();
    checks++;
    if ({score_a, score_b, state} !== {10'd10, 10'd10, 3'd3}) begin
      errors++; $display("FAIL dgoal_enter: got a%0d b%0d s%0d exp a10 b10 s3", score_a, score_b, state);
    end
    prev = state;
    for (int i = 0; i < 200 && !game_over; i++) begin
      step();
      checks++;
      if (obs !== m_vec()) begin
        errors++; $display("FAIL dgoal i%0d: got %h exp %h", i, obs, m_vec());
      end
      if (state == 3'd3 && prev != 3'd3) entries++;
      prev = state;
    end
    checks++;
    if (entries != 0 || {game_over, winner} !== 3'b111) begin
      errors++; $display("FAIL dgoal_end: got extra_holds %0d go%b w%b exp 0 go1 w11", entries, game_over, winner);
    end
  endtask

  task automatic test_double_snitch();
    hard_reset();
    start_p = 1; step();
    repeat (20 + $urandom_range(0, 8)) step();
    snitch_a_p = 1; snitch_b_p = 1; step();
    checks++;
    if ({score_a, score_b, state, winner, time_left} !== {10'd150, 10'd0, 3'd4, 2'b01, 8'd3}) begin
      errors++; $display("FAIL dsnitch: got a%0d b%0d s%0d w%b t%0d exp a150 b0 s4 w01 t3",
                         score_a, score_b, state, winner, time_left);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (time_left !== 8'd3 || obs !== m_vec()) begin
        errors++; $display("FAIL dsnitch_hold i%0d: got %h exp %h", i, obs, m_vec());
      end
    end
  endtask

  task automatic test_pause();
    int n = 0;
    hard_reset();
    start_p = 1; step();
    repeat (4) step();
    pause_p = 1; step();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL pause_enter: got %0d exp 2", state); end
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if ({state, time_left} !== {3'd2, 8'd5} || obs !== m_vec()) begin
        errors++; $display("FAIL paused i%0d: got %h exp %h", i, obs, m_vec());
      end
    end
    pause_p = 1; step();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL pause_resume: got %0d exp 1", state); end
    while (time_left == 8'd5 && n < 30) begin step(); n++; end
    checks++;
    if (n != 6) begin errors++; $display("FAIL pause_next_dec: got %0d exp 6", n); end
  endtask

  task automatic test_goal_final_tick();
    hard_reset();
    start_p = 1; step();
    repeat (49) step();
    goal_b_p = 1; step();
    checks++;
    if ({state, score_b, time_left, winner} !== {3'd4, 10'd10, 8'd0, 2'b10}) begin
      errors++; $display("FAIL final_goal: got s%0d b%0d t%0d w%b exp s4 b10 t0 w10",
                         state, score_b, time_left, winner);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 3'd4 || obs !== m_vec()) begin
        errors++; $display("FAIL final_goal_stay i%0d: got %h exp %h", i, obs, m_vec());
      end
    end
  endtask

  task automatic test_restart_in_over();
    start_p = 1; step();
    checks++;
    if ({state, score_a, score_b, time_left, winner} !== {3'd1, 10'd0, 10'd0, 8'd5, 2'b00}) begin
      errors++; $display("FAIL restart: got s%0d a%0d b%0d t%0d w%b exp s1 a0 b0 t5 w00",
                         state, score_a, score_b, time_left, winner);
    end
  endtask

  task automatic test_reset_in_hold();
    hard_reset();
    start_p = 1; step();
    repeat (3) step();
    goal_a_p = 1; step();
    repeat (5) step();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL rst_hold_pre: got %0d exp 3", state); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== RST_VEC) begin errors++; $display("FAIL rst_in_hold: got %h exp %h", obs, RST_VEC); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start_p    = ($urandom_range(0, 99) < 3);
      pause_p    = ($urandom_range(0, 99) < 3);
      goal_a_p   = ($urandom_range(0, 99) < 4);
      goal_b_p   = ($urandom_range(0, 99) < 4);
      snitch_a_p = ($urandom_range(0, 199) < 1);
      snitch_b_p = ($urandom_range(0, 199) < 1);
      step();
      if ($urandom_range(0, 499) == 0) hard_reset();
      checks++;
      if (obs !== m_vec()) begin
        errors++; $display("FAIL random i%0d: got %h exp %h", i, obs, m_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start_p = 0; pause_p = 0; goal_a_p = 0; goal_b_p = 0; snitch_a_p = 0; snitch_b_p = 0;
    model_reset();
    test_reset();
    test_full_match();
    test_goal_hold();
    test_double_goal();
    test_double_snitch();
    test_pause();
    test_goal_final_tick();
    test_restart_in_over();
    test_reset_in_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
